matrix_ram: RTL and testbench

- Parametrised N x N word store for the matrix datapath; successor to the fixed 8x8 column-read RAM.
- Adds row or column read mode, a registered read port with a valid flag, and a streaming raster-order loader with a valid/ready handshake.
- Sits between the operand loader and the systolic/PE array. Each read delivers one full row or column.

---
 rtl/matrix_ram_if.sv | 39 +++
 rtl/matrix_ram.sv | 110 +++++++++++
 tb/tb_matrix_ram.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/matrix_ram_if.sv
// Bus bundle for matrix_ram: direct write port, row/column read port and
// the streaming raster loader handshake.
interface matrix_ram_if #(
    parameter int SIZE = 16,
    parameter int N    = 8,
    parameter int AW   = $clog2(N)
);
    logic            wen;
    logic [AW-1:0]   wi_address;
    logic [AW-1:0]   wj_address;
    logic [SIZE-1:0] w_data;

    logic            ren;
    logic            r_mode;
    logic [AW-1:0]   r_index;
    logic [N*SIZE-1:0] r_data;
    logic            r_valid;

    logic            ld_start;
    logic            ld_valid;
    logic [SIZE-1:0] ld_data;
    logic            ld_ready;
    logic            ld_busy;
    logic            ld_done;

    modport master (
        output wen, wi_address, wj_address, w_data,
        output ren, r_mode, r_index,
        output ld_start, ld_valid, ld_data,
        input  r_data, r_valid, ld_ready, ld_busy, ld_done
    );

    modport slave (
        input  wen, wi_address, wj_address, w_data,
        input  ren, r_mode, r_index,
        input  ld_start, ld_valid, ld_data,
        output r_data, r_valid, ld_ready, ld_busy, ld_done
    );
endinterface

// File: rtl/matrix_ram.sv
// N x N word store with registered row/column reads and a raster-order streaming loader.
// Optional macro READ_BYPASS_EN forwards same-cycle write data into the read vector.
//
// state | meaning
// IDLE  | loader inactive, direct writes allowed
// LOAD  | accepting raster beats, direct writes blocked
// DONE  | one-cycle completion pulse after the final beat
module matrix_ram #(
    parameter int SIZE = 16,
    parameter int N    = 8,
    parameter int AW   = $clog2(N)
) (
    input  logic        clock,
    input  logic        reset,
    matrix_ram_if.slave bus
);
    localparam int CW = 2*AW + 1;
    localparam logic [CW-1:0] LAST = CW'(N*N - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [SIZE-1:0]   r_mem [N*N];
    logic [N*SIZE-1:0] r_data;
    logic              r_valid;

    logic              w_ld_ready, w_ld_busy, w_ld_done;
    logic              w_ld_we, w_dir_we, w_we;
    logic [2*AW-1:0]   w_waddr;
    logic [SIZE-1:0]   w_wdata;
    logic [2*AW-1:0]   w_rd_addr [N];
    logic [N*SIZE-1:0] w_rd_vec;

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ld_ready  = 1'b0;
        w_ld_busy   = 1'b0;
        w_ld_done   = 1'b0;
        case (r_state)
            IDLE: if (bus.ld_start) w_state_nxt = LOAD;
            LOAD: begin
                w_ld_ready = 1'b1;
                w_ld_busy  = 1'b1;
                if (bus.ld_valid && r_cnt == LAST) w_state_nxt = DONE;
            end
            DONE: begin
                w_ld_busy   = 1'b1;
                w_ld_done   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)                             r_cnt <= '0;
        else if (r_state == IDLE && bus.ld_start) r_cnt <= '0;
        else if (w_ld_we)                      r_cnt <= r_cnt + CW'(1);
    end

    // With N a power of two, the low 2*AW counter bits are exactly i*N+j.
    assign w_ld_we  = w_ld_ready && bus.ld_valid;
    assign w_dir_we = bus.wen && !w_ld_busy;
    assign w_we     = w_ld_we || w_dir_we;
    assign w_waddr  = w_ld_we ? r_cnt[2*AW-1:0] : {bus.wi_address, bus.wj_address};
    assign w_wdata  = w_ld_we ? bus.ld_data : bus.w_data;

    always_ff @(posedge clock) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            w_rd_addr[k] = bus.r_mode ? {bus.r_index, AW'(k)} : {AW'(k), bus.r_index};
        end
    end

    // Element 0 lands in the MSBs of the read vector.
    always_comb begin
        w_rd_vec = '0;
        for (int k = 0; k < N; k++) begin
            w_rd_vec[(N-k)*SIZE-1 -: SIZE] = r_mem[w_rd_addr[k]];
`ifdef READ_BYPASS_EN
            if (w_we && w_waddr == w_rd_addr[k]) w_rd_vec[(N-k)*SIZE-1 -: SIZE] = w_wdata;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.ren;
            if (bus.ren) r_data <= w_rd_vec;
        end
    end

    assign bus.r_data   = r_data;
    assign bus.r_valid  = r_valid;
    assign bus.ld_ready = w_ld_ready;
    assign bus.ld_busy  = w_ld_busy;
    assign bus.ld_done  = w_ld_done;
endmodule

// File: tb/tb_matrix_ram.sv
// Scoreboard bench for matrix_ram: an 8x8x16 instance and a 4x4x8 instance
// share one clock; reads push expected vectors, a negedge monitor pops them.
module tb_matrix_ram;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst8, rst4;

    matrix_ram_if #(.SIZE(16), .N(8)) bus8();
    matrix_ram_if #(.SIZE(8),  .N(4)) bus4();

    matrix_ram #(.SIZE(16), .N(8)) u_dut8 (.clock(clk), .reset(rst8), .bus(bus8.slave));
    matrix_ram #(.SIZE(8),  .N(4)) u_dut4 (.clock(clk), .reset(rst4), .bus(bus4.slave));

    int checks = 0;
    int errors = 0;
    int done8  = 0;
    int done4  = 0;
    logic [127:0] q8 [$];
    logic [31:0]  q4 [$];

`ifdef READ_BYPASS_EN
    localparam logic [15:0] COL_E2 = 16'hBEEF;
`else
    localparam logic [15:0] COL_E2 = 16'h0014;
`endif

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (bus8.ld_done) done8++;
        if (bus4.ld_done) done4++;
        if (bus8.r_valid) begin
            if (q8.size() == 0) chk("rd8 unexpected r_valid", {127'b0, bus8.r_valid}, 128'd0);
            else                chk("rd8", bus8.r_data, q8.pop_front());
        end
        if (bus4.r_valid) begin
            if (q4.size() == 0) chk("rd4 unexpected r_valid", {127'b0, bus4.r_valid}, 128'd0);
            else                chk("rd4", {96'b0, bus4.r_data}, {96'b0, q4.pop_front()});
        end
    end

    task automatic read8(input logic mode, input logic [2:0] idx, input logic [127:0] exp);
        bus8.ren = 1'b1; bus8.r_mode = mode; bus8.r_index = idx;
        q8.push_back(exp);
        tick();
        bus8.ren = 1'b0;
    endtask

    task automatic read4(input logic mode, input logic [1:0] idx, input logic [31:0] exp);
        bus4.ren = 1'b1; bus4.r_mode = mode; bus4.r_index = idx;
        q4.push_back(exp);
        tick();
        bus4.ren = 1'b0;
    endtask

    // Every third cycle ld_valid drops; optional wen attempt at beat wen_at.
    task automatic load8(input logic [15:0] base, input int nb, input int wen_at);
        int n = 0;
        int c = 0;
        logic acc;
        bus8.ld_start = 1'b1; tick(); bus8.ld_start = 1'b0;
        while (n < nb && c < 400) begin
            bus8.ld_valid   = (c % 3 != 2);
            bus8.ld_data    = base + 16'(n);
            bus8.wen        = (n == wen_at);
            bus8.wi_address = 3'd0; bus8.wj_address = 3'd0; bus8.w_data = 16'hFFFF;
            acc = bus8.ld_valid && bus8.ld_ready;
            tick();
            if (acc) n++;
            c++;
        end
        bus8.ld_valid = 1'b0; bus8.wen = 1'b0;
        if (n < nb) chk("load8 beat budget", 128'(n), 128'(nb));
    endtask

    task automatic load4(input logic [7:0] base, input int nb);
        int n = 0;
        int c = 0;
        logic acc;
        bus4.ld_start = 1'b1; tick(); bus4.ld_start = 1'b0;
        while (n < nb && c < 200) begin
            bus4.ld_valid = (c % 3 != 2);
            bus4.ld_data  = base + 8'(n);
            acc = bus4.ld_valid && bus4.ld_ready;
            tick();
            if (acc) n++;
            c++;
        end
        bus4.ld_valid = 1'b0;
        if (n < nb) chk("load4 beat budget", 128'(n), 128'(nb));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus8.wen = 0; bus8.wi_address = 0; bus8.wj_address = 0; bus8.w_data = 0;
        bus8.ren = 0; bus8.r_mode = 0; bus8.r_index = 0;
        bus8.ld_start = 0; bus8.ld_valid = 0; bus8.ld_data = 0;
        bus4.wen = 0; bus4.wi_address = 0; bus4.wj_address = 0; bus4.w_data = 0;
        bus4.ren = 0; bus4.r_mode = 0; bus4.r_index = 0;
        bus4.ld_start = 0; bus4.ld_valid = 0; bus4.ld_data = 0;
        rst8 = 1'b1; rst4 = 1'b1;
        repeat (2) tick();
        rst8 = 1'b0; rst4 = 1'b0;

        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("idle r_data", bus8.r_data, 128'd0);
            chk("idle flags", {124'b0, bus8.r_valid, bus8.ld_ready, bus8.ld_busy, bus8.ld_done}, 128'd0);
        end
        tick();

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                bus8.wen = 1'b1; bus8.wi_address = 3'(i); bus8.wj_address = 3'(j);
                bus8.w_data = 16'(i*16 + j);
                tick();
            end
        end
        bus8.wen = 1'b0;

        read8(1'b0, 3'd3, 128'h0003_0013_0023_0033_0043_0053_0063_0073);
        read8(1'b1, 3'd5, 128'h0050_0051_0052_0053_0054_0055_0056_0057);
        repeat (3) tick();
        @(negedge clk);
        chk("r_data hold", bus8.r_data, 128'h0050_0051_0052_0053_0054_0055_0056_0057);
        tick();

        load8(16'h0000, 64, 60);
        @(negedge clk);
        chk("ld_done one cycle after last beat", {125'b0, bus8.ld_done, bus8.ld_busy, bus8.ld_ready}, 128'b110);
        tick();
        @(negedge clk);
        chk("back to idle", {125'b0, bus8.ld_done, bus8.ld_busy, bus8.ld_ready}, 128'b000);
        tick();
        read8(1'b1, 3'd7, 128'h0038_0039_003A_003B_003C_003D_003E_003F);
        read8(1'b1, 3'd0, 128'h0000_0001_0002_0003_0004_0005_0006_0007);

        load8(16'h0A00, 10, -1);
        rst8 = 1'b1; tick(); rst8 = 1'b0;
        @(negedge clk);
        chk("reset mid-load flags", {125'b0, bus8.ld_done, bus8.ld_busy, bus8.ld_ready}, 128'b000);
        tick();
        read8(1'b1, 3'd0, 128'h0A00_0A01_0A02_0A03_0A04_0A05_0A06_0A07);
        read8(1'b1, 3'd1, 128'h0A08_0A09_000A_000B_000C_000D_000E_000F);

        load8(16'h1200, 2, -1);
        rst8 = 1'b1; tick(); rst8 = 1'b0;
        read8(1'b1, 3'd0, 128'h1200_1201_0A02_0A03_0A04_0A05_0A06_0A07);

        bus8.wen = 1'b1; bus8.wi_address = 3'd2; bus8.wj_address = 3'd4; bus8.w_data = 16'hBEEF;
        read8(1'b0, 3'd4, {16'h0A04, 16'h000C, COL_E2, 16'h001C, 16'h0024, 16'h002C, 16'h0034, 16'h003C});
        bus8.wen = 1'b0;
        read8(1'b0, 3'd4, {16'h0A04, 16'h000C, 16'hBEEF, 16'h001C, 16'h0024, 16'h002C, 16'h0034, 16'h003C});

        load4(8'hA0, 16);
        @(negedge clk);
        chk("n4 ld_done", {125'b0, bus4.ld_done, bus4.ld_busy, bus4.ld_ready}, 128'b110);
        tick();
        read4(1'b1, 2'd3, 32'hACAD_AEAF);
        read4(1'b0, 2'd1, 32'hA1A5_A9AD);

        repeat (4) tick();
        chk("n8 ld_done pulse count", 128'(done8), 128'd1);
        chk("n4 ld_done pulse count", 128'(done4), 128'd1);
        chk("n8 scoreboard drained", 128'(q8.size()), 128'd0);
        chk("n4 scoreboard drained", 128'(q4.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
